modadder_ctrl: RTL and testbench

//  Modular add/subtract sequencer; initiator side of the mpadder start/done handshake.

---
 rtl/modadder_ctrl.sv | 121 ++++++++++++
 tb/tb_modadder_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modadder_ctrl.sv
// Modular add/subtract sequencer: drives a shared mpadder through two operations
// (raw add/sub, then the +/-M correction) and selects the reduced result by sign.
module modadder_ctrl #(
  parameter int WIDTH = 1027
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_in_a,
  output logic [WIDTH-1:0] add_in_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE1 = 3'd1,
    WAIT1  = 3'd2,
    ISSUE2 = 3'd3,
    WAIT2  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] m_reg;
  logic             op_reg;
  logic [WIDTH:0]   tmp_reg;
  logic [WIDTH-1:0] issue_a;
  logic [WIDTH-1:0] issue_b;
  logic             issue_sub;
  logic [WIDTH-1:0] result_next;

  // Operand values are chosen here on the transition into an ISSUE state, so the
  // registered mpadder inputs are already valid in the cycle add_start is high.
  always_comb begin
    state_next  = state;
    issue_a     = add_in_a;
    issue_b     = add_in_b;
    issue_sub   = add_subtract;
    result_next = result;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ISSUE1;
          issue_a    = in_a;
          issue_b    = in_b;
          issue_sub  = subtract;
        end
      end
      ISSUE1: state_next = WAIT1;
      WAIT1: begin
        if (add_done) begin
          state_next = ISSUE2;
          issue_a    = add_result[WIDTH-1:0];
          issue_b    = m_reg;
          issue_sub  = ~op_reg;
        end
      end
      ISSUE2: state_next = WAIT2;
      WAIT2: begin
        if (add_done) begin
          state_next = DONE;
          // Add keeps s-M unless it went negative; sub adds M back only if a-b was negative.
          if (op_reg)
            result_next = tmp_reg[WIDTH] ? add_result[WIDTH-1:0] : tmp_reg[WIDTH-1:0];
          else
            result_next = add_result[WIDTH] ? tmp_reg[WIDTH-1:0] : add_result[WIDTH-1:0];
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result       <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
      m_reg        <= '0;
      op_reg       <= 1'b0;
      tmp_reg      <= '0;
    end else begin
      add_start    <= (state_next == ISSUE1) || (state_next == ISSUE2);
      done         <= (state_next == DONE);
      busy         <= (state_next != IDLE);
      add_in_a     <= issue_a;
      add_in_b     <= issue_b;
      add_subtract <= issue_sub;
      result       <= result_next;
      if (state == IDLE && start) begin
        m_reg  <= in_m;
        op_reg <= subtract;
      end
      if (state == WAIT1 && add_done)
        tmp_reg <= add_result;
    end
  end

endmodule

// File: tb/tb_modadder_ctrl.sv
// Directed and random bench for modadder_ctrl with a behavioural mpadder whose
// latency is 2 cycles for add and 3 cycles for subtract.
module tb_modadder_ctrl;

  localparam int WIDTH     = 1027;
  localparam int LAT_ADD   = 2;
  localparam int LAT_SUB   = 3;
  localparam int OP_CYCLES = LAT_ADD + LAT_SUB + 3;
  localparam int MAX_WAIT  = 100;

  typedef logic [WIDTH:0] wide_t;

  logic             clk;
  logic             resetn;
  logic             start;
  logic             subtract;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             add_start;
  logic             add_subtract;
  logic [WIDTH-1:0] add_in_a;
  logic [WIDTH-1:0] add_in_b;
  logic [WIDTH:0]   add_result;
  logic             add_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int back_to_back = 0;
  logic prev_add_start = 1'b0;

  modadder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .subtract     (subtract),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_m         (in_m),
    .result       (result),
    .done         (done),
    .busy         (busy),
    .add_start    (add_start),
    .add_subtract (add_subtract),
    .add_in_a     (add_in_a),
    .add_in_b     (add_in_b),
    .add_result   (add_result),
    .add_done     (add_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural mpadder: result captured at the start edge, done pulses L cycles
  // after the add_start cycle.
  int mp_cnt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      add_result <= '0;
      add_done   <= 1'b0;
      mp_cnt     <= 0;
    end else begin
      add_done <= 1'b0;
      if (add_start) begin
        add_result <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                   : ({1'b0, add_in_a} + {1'b0, add_in_b});
        mp_cnt     <= add_subtract ? LAT_SUB - 1 : LAT_ADD - 1;
      end else if (mp_cnt == 1) begin
        add_done <= 1'b1;
        mp_cnt   <= 0;
      end else if (mp_cnt > 1) begin
        mp_cnt <= mp_cnt - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input wide_t observed, input wide_t expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (low 256 bits)",
               tag, observed[255:0], expected[255:0]);
    end
  endtask

  function automatic wide_t mod_ref(input bit op, input wide_t a, input wide_t b, input wide_t m);
    wide_t s;
    if (!op) begin
      s = a + b;
      if (s >= m) s = s - m;
    end else begin
      s = (a >= b) ? (a - b) : (a + m - b);
    end
    return s;
  endfunction

  function automatic wide_t rand1024();
    wide_t v = '0;
    for (int i = 0; i < 32; i++) v = (v << 32) | wide_t'($urandom);
    return v;
  endfunction

  // Samples one negedge per cycle until done, counting add_start pulses.
  task automatic waitDone(inout int cycles, inout int starts, output bit ok);
    ok = 1'b0;
    while (cycles < MAX_WAIT) begin
      if (add_start) starts++;
      if (add_start && prev_add_start) back_to_back++;
      prev_add_start = add_start;
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic pulseStart(input bit op, input wide_t a, input wide_t b, input wide_t m);
    @(negedge clk);
    start    = 1'b1;
    subtract = op;
    in_a     = a[WIDTH-1:0];
    in_b     = b[WIDTH-1:0];
    in_m     = m[WIDTH-1:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input bit op, input wide_t a, input wide_t b, input wide_t m,
                               output wide_t res, output int cycles, output int starts);
    bit ok;
    pulseStart(op, a, b, m);
    cycles = 1;
    starts = 0;
    waitDone(cycles, starts, ok);
    if (!ok) checkOutput("done_timeout", 0, 1);
    res = {1'b0, result};
  endtask

  task automatic directed(input string tag, input bit op, input wide_t a, input wide_t b,
                          input wide_t m, input wide_t expected);
    wide_t res;
    int    cycles;
    int    starts;
    applyStimulus(op, a, b, m, res, cycles, starts);
    checkOutput({tag, "_result"}, res, expected);
    checkOutput({tag, "_starts"}, wide_t'(starts), 2);
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, wide_t'(done), 0);
    checkOutput({tag, "_busy_after"}, wide_t'(busy), 0);
  endtask

  initial begin
    wide_t res, big_m, a, b, m, expv;
    int    cycles, starts, stray, prev_done_cyc;
    bit    ok, op;

    resetn   = 1'b0;
    start    = 1'b0;
    subtract = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_m     = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_result", {1'b0, result}, 0);
    checkOutput("reset_done", wide_t'(done), 0);
    checkOutput("reset_busy", wide_t'(busy), 0);
    checkOutput("reset_add_start", wide_t'(add_start), 0);
    checkOutput("reset_add_in_a", {1'b0, add_in_a}, 0);
    resetn = 1'b1;

    $display("[TB] T1 modular add");
    directed("t1_add_5_7", 1'b0, 5, 7, 11, 1);
    directed("t1_add_3_4", 1'b0, 3, 4, 11, 7);

    $display("[TB] T2 modular subtract");
    directed("t2_sub_3_7", 1'b1, 3, 7, 11, 7);
    directed("t2_sub_9_9", 1'b1, 9, 9, 11, 0);
    directed("t2_sub_10_0", 1'b1, 10, 0, 11, 10);

    $display("[TB] T3 wide boundary values");
    big_m = (wide_t'(1) << 1025) - 1;
    directed("t3_add_max", 1'b0, big_m - 1, big_m - 1, big_m, big_m - 2);
    directed("t3_sub_wrap", 1'b1, 0, big_m - 1, big_m, 1);

    $display("[TB] T4 start ignored while busy");
    @(negedge clk);
    start = 1'b1; subtract = 1'b0; in_a = 5; in_b = 7; in_m = 11;
    @(negedge clk);
    start = 1'b0;
    cycles = 1; starts = 0;
    if (add_start) starts++;
    @(negedge clk);
    cycles++;
    start = 1'b1; subtract = 1'b1; in_a = 1; in_b = 2; in_m = 13;
    checkOutput("t4_busy_wait1", wide_t'(busy), 1);
    if (add_start) starts++;
    @(negedge clk);
    cycles++;
    start = 1'b0;
    waitDone(cycles, starts, ok);
    if (!ok) checkOutput("t4_done_timeout", 0, 1);
    checkOutput("t4_result", {1'b0, result}, 1);
    checkOutput("t4_starts", wide_t'(starts), 2);
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || add_start) stray++;
    end
    checkOutput("t4_no_queued_op", wide_t'(stray), 0);

    $display("[TB] T5 reset during second operation");
    pulseStart(1'b0, 5, 7, 11);
    starts = 0;
    for (int i = 0; i < MAX_WAIT && starts < 2; i++) begin
      if (add_start) starts++;
      if (starts < 2) @(negedge clk);
    end
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t5_rst_done", wide_t'(done), 0);
    checkOutput("t5_rst_result", {1'b0, result}, 0);
    checkOutput("t5_rst_add_start", wide_t'(add_start), 0);
    checkOutput("t5_rst_busy", wide_t'(busy), 0);
    resetn = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    checkOutput("t5_no_pending_done", wide_t'(stray), 0);
    directed("t5_add_after_reset", 1'b0, 5, 7, 11, 1);

    $display("[TB] T6 random back-to-back");
    prev_done_cyc = -1;
    back_to_back  = 0;
    for (int i = 0; i < 200; i++) begin
      m = rand1024();
      m[1023] = 1'b1;
      a  = rand1024() % m;
      b  = rand1024() % m;
      op = 1'($urandom_range(0, 1));
      expv = mod_ref(op, a, b, m);
      applyStimulus(op, a, b, m, res, cycles, starts);
      checkOutput("t6_result", res, expv);
      checkOutput("t6_latency", wide_t'(cycles), OP_CYCLES);
      if (prev_done_cyc >= 0)
        checkOutput("t6_spacing", wide_t'(cyc - prev_done_cyc), OP_CYCLES + 1);
      prev_done_cyc = cyc;
    end
    checkOutput("t6_no_adjacent_add_start", wide_t'(back_to_back), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
